// File: rtl/aurora_tx_scheduler_if.sv
// Bundle of signals between the Aurora TX scheduler, its packet sources and the TX FIFO.
// The scheduler connects through the master modport; the environment uses the slave modport.
interface aurora_tx_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 256
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                    channel_up;
  logic                    full;
  logic [DW-1:0]           din;
  logic                    wr_en;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*DW-1:0]   req_data;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    busy;
  logic [IDW-1:0]          grant_id;

  modport master (
    input  channel_up, full, req_valid, req_data, req_last,
    output din, wr_en, req_ready, busy, grant_id
  );

  modport slave (
    output channel_up, full, req_valid, req_data, req_last,
    input  din, wr_en, req_ready, busy, grant_id
  );
endinterface

// File: rtl/aurora_tx_scheduler.sv
// Round-robin scheduler sharing one Aurora TX FIFO between NUM_REQ packet sources.
// Each granted packet is framed as HEADER, payload words, TRAILER through a single
// output register (din/out_valid) that supports back-to-back writes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no packet in flight; arbitrate when channel_up
// ST_HDR   | source granted; waiting for slot to load the header
// ST_PAY   | forwarding payload words of the granted source
// ST_TRL   | last payload word taken; waiting for slot to load trailer
module aurora_tx_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 256
) (
  input  logic                   user_clk,
  input  logic                   peripheral_reset,
  aurora_tx_scheduler_if.master  bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDW:0] NR_W = (IDW+1)'(NUM_REQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  localparam logic [1:0] ST_TRL  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       din_q, din_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [15:0]         word_cnt_q, word_cnt_d;
  logic [15:0]         seq_q [NUM_REQ];
  logic [15:0]         seq_d [NUM_REQ];

  logic                slot_free;
  logic                wr_en;
  logic                load;
  logic [DW-1:0]       load_word;
  logic [NUM_REQ-1:0]  ready_vec;

  logic [2*NUM_REQ-1:0] rot_valid_dbl;
  logic [NUM_REQ-1:0]   rot_valid;
  logic [IDW-1:0]       pick_off;
  logic [IDW:0]         pick_sum;
  logic [IDW-1:0]       pick_id;
  logic                 pick_found;
  logic [IDW:0]         rr_next_sum;
  logic [IDW-1:0]       rr_next;

  logic                cur_valid;
  logic                cur_last;
  logic [DW-1:0]       cur_data;
  logic [15:0]         cur_seq;
  logic [DW-1:0]       hdr_word;
  logic [DW-1:0]       trl_word;

  // A word leaves the slot whenever it is valid and the FIFO has room; the slot may
  // be refilled in that same cycle.
  assign wr_en     = out_valid_q & ~bus.full;
  assign slot_free = ~out_valid_q | ~bus.full;

  // Round-robin search: rotate the valids so bit k is source (rr_ptr + k) mod NUM_REQ
  always_comb begin
    rot_valid_dbl = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
    rot_valid     = rot_valid_dbl[NUM_REQ-1:0];
    pick_found    = 1'b0;
    pick_off      = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        pick_found = 1'b1;
        pick_off   = IDW'(k);
      end
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    if (pick_sum >= NR_W) begin
      pick_sum = pick_sum - NR_W;
    end
    pick_id = pick_sum[IDW-1:0];
  end

  // Pointer for the next arbitration: the source after the one just served
  always_comb begin
    rr_next_sum = {1'b0, grant_q} + {{IDW{1'b0}}, 1'b1};
    if (rr_next_sum >= NR_W) begin
      rr_next = '0;
    end else begin
      rr_next = rr_next_sum[IDW-1:0];
    end
  end

  // Select the granted source's handshake, data and sequence number
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    cur_seq   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDW'(i)) begin
        cur_valid = bus.req_valid[i];
        cur_last  = bus.req_last[i];
        cur_data  = bus.req_data[i*DW +: DW];
        cur_seq   = seq_q[i];
      end
    end
  end

  // Build header and trailer framing words for the granted source
  always_comb begin
    hdr_word                = '0;
    hdr_word[DW-1  -: 8]    = 8'hA5;
    hdr_word[DW-9  -: 8]    = 8'(grant_q);
    hdr_word[DW-17 -: 16]   = cur_seq;
    trl_word                = '0;
    trl_word[DW-1  -: 8]    = 8'h5A;
    trl_word[DW-9  -: 8]    = 8'(grant_q);
    trl_word[DW-17 -: 16]   = cur_seq;
    trl_word[DW-33 -: 16]   = word_cnt_q;
  end

  // Packet framing FSM: arbitration, header, payload forwarding, trailer
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    word_cnt_d = word_cnt_q;
    seq_d      = seq_q;
    load       = 1'b0;
    load_word  = din_q;
    ready_vec  = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.channel_up && pick_found) begin
          grant_d    = pick_id;
          word_cnt_d = '0;
          state_d    = ST_HDR;
        end
      end
      ST_HDR: begin
        if (slot_free) begin
          load      = 1'b1;
          load_word = hdr_word;
          state_d   = ST_PAY;
        end
      end
      ST_PAY: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          ready_vec[i] = slot_free && (grant_q == IDW'(i));
        end
        if (cur_valid && slot_free) begin
          load      = 1'b1;
          load_word = cur_data;
          if (word_cnt_q != 16'hFFFF) begin
            word_cnt_d = word_cnt_q + 16'd1;
          end
          if (cur_last) begin
            state_d = ST_TRL;
          end
        end
      end
      ST_TRL: begin
        if (slot_free) begin
          load      = 1'b1;
          load_word = trl_word;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
              seq_d[i] = seq_q[i] + 16'd1;
            end
          end
          rr_ptr_d = rr_next;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output slot: load wins, otherwise a written word empties the slot; din holds otherwise
  always_comb begin
    if (load) begin
      out_valid_d = 1'b1;
      din_d       = load_word;
    end else begin
      out_valid_d = out_valid_q & ~wr_en;
      din_d       = din_q;
    end
  end

  // State registers; reset drops any packet in flight without a trailer
  always_ff @(posedge user_clk or posedge peripheral_reset) begin
    if (peripheral_reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      din_q       <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      word_cnt_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        seq_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      din_q       <= din_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      word_cnt_q  <= word_cnt_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        seq_q[i] <= seq_d[i];
      end
    end
  end

  assign bus.din       = din_q;
  assign bus.wr_en     = wr_en;
  assign bus.req_ready = ready_vec;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_aurora_tx_scheduler.sv
// Scoreboard bench for aurora_tx_scheduler: packets are issued per source, the expected
// FIFO word stream is predicted from the round-robin/framing rules and checked by a monitor.
module tb_aurora_tx_scheduler;
  localparam int N   = 3;
  localparam int DW  = 256;

  logic user_clk = 1'b0;
  logic peripheral_reset;
  always #5 user_clk = ~user_clk;

  aurora_tx_scheduler_if #(.NUM_REQ(N), .DW(DW)) bus ();

  aurora_tx_scheduler #(.NUM_REQ(N), .DW(DW)) dut (
    .user_clk         (user_clk),
    .peripheral_reset (peripheral_reset),
    .bus              (bus)
  );

  typedef struct {
    logic [DW-1:0] word;
    bit            is_hdr;
    int            id;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] src_q [N][$];
  bit            started [N];
  logic [N-1:0]  xfer_s;
  int            n_pass, n_total, n_writes, cyc;
  int            seq_m [N];
  int            rr_m;
  bit            rand_env, full_force, chan_low, noise, lat_arm;
  int            lat_vcyc;
  int            wr_cyc [$];

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [DW-1:0] mk_hdr(input int id, input int seq);
    logic [DW-1:0] w;
    w = '0;
    w[255:248] = 8'hA5;
    w[247:240] = 8'(id);
    w[239:224] = 16'(seq);
    return w;
  endfunction

  function automatic logic [DW-1:0] mk_trl(input int id, input int seq, input int cnt);
    logic [DW-1:0] w;
    w = '0;
    w[255:248] = 8'h5A;
    w[247:240] = 8'(id);
    w[239:224] = 16'(seq);
    w[223:208] = 16'(cnt);
    return w;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Queue one packet on a source and predict the FIFO words it will produce
  task automatic issue_pkt(input int src, input int len);
    logic [DW-1:0] w;
    exp_q.push_back('{mk_hdr(src, seq_m[src]), 1'b1, src});
    for (int j = 0; j < len; j++) begin
      w = rnd_word();
      src_q[src].push_back(w);
      exp_q.push_back('{w, 1'b0, src});
    end
    exp_q.push_back('{mk_trl(src, seq_m[src], len), 1'b0, src});
    seq_m[src] = (seq_m[src] + 1) % 65536;
    rr_m = (src + 1) % N;
    started[src] = 1'b0;
  endtask

  // All sources in mask become valid together; they are served in circular order from rr
  task automatic round(input logic [N-1:0] mask, input int flen);
    int rr0;
    int idx;
    rr0 = rr_m;
    for (int k = 0; k < N; k++) begin
      idx = (rr0 + k) % N;
      if (mask[idx]) issue_pkt(idx, (flen > 0) ? flen : int'($urandom_range(1, 5)));
    end
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      @(negedge user_clk); #4;
      c++;
    end
    chk_i(name, exp_q.size(), 0);
  endtask

  task automatic wait_writes(input string name, input int target, input int maxc);
    int c;
    c = 0;
    while (n_writes < target && c < maxc) begin
      @(negedge user_clk); #4;
      c++;
    end
    if (n_writes < target) chk_i(name, n_writes, target);
  endtask

  // Input driver: applies stimulus on the falling edge, consumes accepted words
  initial begin : driver
    logic [N-1:0] v;
    forever begin
      @(negedge user_clk);
      for (int i = 0; i < N; i++) begin
        if (xfer_s[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          started[i] = 1'b1;
        end
      end
      xfer_s = '0;
      for (int i = 0; i < N; i++) begin
        if (noise) v[i] = 1'($urandom_range(0, 1));
        else if (src_q[i].size() > 0)
          v[i] = !started[i] || !rand_env || ($urandom_range(0, 3) != 0);
        else v[i] = 1'b0;
        bus.req_valid[i] = v[i];
        if (v[i] && !noise) begin
          bus.req_data[i*DW +: DW] = src_q[i][0];
          bus.req_last[i]          = (src_q[i].size() == 1);
        end else begin
          bus.req_data[i*DW +: DW] = rnd_word();
          bus.req_last[i]          = 1'($urandom_range(0, 1));
        end
      end
      bus.full       = full_force || (rand_env && $urandom_range(0, 3) == 0);
      bus.channel_up = !chan_low && !(rand_env && $urandom_range(0, 7) == 0);
    end
  end

  // Monitor: samples just before the rising edge and checks every FIFO write
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge user_clk); #4;
      cyc++;
      xfer_s = bus.req_valid & bus.req_ready;
      if (lat_arm && lat_vcyc < 0 && bus.req_valid != '0) lat_vcyc = cyc;
      if (bus.full) chk_i("wr_en_while_full", int'(bus.wr_en), 0);
      if (bus.wr_en) begin
        n_writes++;
        if (lat_arm) wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got din %h with no word expected", bus.din);
        end else begin
          e = exp_q.pop_front();
          chk_w(e.is_hdr ? "hdr_word" : "fifo_word", bus.din, e.word);
          if (e.is_hdr) chk_i("hdr_grant_id", int'(bus.grant_id), e.id);
        end
      end
    end
  end

  initial begin : main
    logic [DW-1:0] d0;
    int base;
    n_pass = 0; n_total = 0; n_writes = 0; cyc = 0;
    rr_m = 0; xfer_s = '0; lat_arm = 0; lat_vcyc = -1;
    for (int i = 0; i < N; i++) begin seq_m[i] = 0; started[i] = 1'b0; end
    full_force = 0; chan_low = 0; noise = 1; rand_env = 1;
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
    bus.full = 1'b0; bus.channel_up = 1'b0;
    peripheral_reset = 1'b1;

    // Reset held while inputs toggle
    repeat (8) begin
      @(negedge user_clk); #4;
      chk_i("rst_quiet", int'({bus.wr_en, bus.req_ready, bus.busy}), 0);
    end
    chk_w("rst_din", bus.din, '0);
    chk_i("rst_grant", int'(bus.grant_id), 0);
    noise = 0; rand_env = 0;
    @(negedge user_clk);
    peripheral_reset = 1'b0;
    repeat (2) @(negedge user_clk);

    // Single 3-word packet, latency and back-to-back writes
    wr_cyc.delete(); lat_vcyc = -1; lat_arm = 1;
    issue_pkt(0, 3);
    wait_drain("drain_single", 100);
    lat_arm = 0;
    chk_i("single_write_count", wr_cyc.size(), 5);
    if (wr_cyc.size() >= 5) begin
      chk_i("hdr_latency", wr_cyc[0] - lat_vcyc, 2);
      chk_i("consecutive_writes", wr_cyc[4] - wr_cyc[0], 4);
    end

    // Two sources continuously valid, alternating grants
    repeat (3) begin
      round(3'b011, 2);
      wait_drain("drain_alt", 200);
    end

    // FIFO full for 4 cycles mid-payload
    base = n_writes;
    issue_pkt(2, 5);
    wait_writes("stall_reach", base + 2, 100);
    full_force = 1;
    @(negedge user_clk); #4;
    d0 = bus.din;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge user_clk); #4; end
      chk_i("stall_wr_en", int'(bus.wr_en), 0);
      chk_i("stall_ready", int'(bus.req_ready[2]), 0);
      chk_w("stall_din", bus.din, d0);
    end
    full_force = 0;
    wait_drain("drain_stall", 100);

    // channel_up low blocks new packets but not one in flight
    chan_low = 1;
    base = n_writes;
    issue_pkt(1, 2);
    repeat (10) @(negedge user_clk);
    #4;
    chk_i("chan_down_busy", int'(bus.busy), 0);
    chk_i("chan_down_writes", n_writes - base, 0);
    chan_low = 0;
    wait_writes("chan_reach", base + 2, 100);
    chan_low = 1;
    issue_pkt(0, 2);
    wait_writes("chan_finish", base + 4, 100);
    base = n_writes;
    repeat (10) @(negedge user_clk);
    #4;
    chk_i("chan_hold_writes", n_writes - base, 0);
    chk_i("chan_hold_busy", int'(bus.busy), 0);
    chan_low = 0;
    wait_drain("drain_chan", 100);

    // Asynchronous reset mid-payload
    base = n_writes;
    issue_pkt(2, 6);
    wait_writes("rst_reach", base + 3, 100);
    #2;
    peripheral_reset = 1'b1;
    #1;
    chk_i("async_rst_outs", int'({bus.wr_en, bus.req_ready, bus.busy}), 0);
    chk_w("async_rst_din", bus.din, '0);
    chk_i("async_rst_grant", int'(bus.grant_id), 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin src_q[i].delete(); seq_m[i] = 0; end
    rr_m = 0;
    repeat (2) @(negedge user_clk);
    peripheral_reset = 1'b0;
    @(negedge user_clk);
    issue_pkt(2, 2);
    wait_drain("drain_after_rst", 100);

    // Randomized rounds with FIFO back-pressure, link flaps and source bubbles
    rand_env = 1;
    for (int r = 0; r < 40; r++) begin
      round(3'($urandom_range(1, 7)), 0);
      wait_drain("drain_rand", 600);
    end
    rand_env = 0;
    repeat (4) @(negedge user_clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
